demux1ne8_seq: RTL and testbench
================================

// Module: demux1ne8_seq
// PURPOSE
//   Registered 1-to-8 demultiplexer / deserializer; the inverse of the 8-to-1 select mux.
//   Routes one input word, per valid cycle, into one of eight held output lanes.
//   Lane choice: external Sel (manual) or an internal 3-bit write pointer (auto).
//   Auto mode rebuilds an 8-word frame that an upstream 8:1 mux serialized; DaljaValid flags completion.
// PARAMETERS
//   WIDTH   1   bits per lane (Hyrja and each Dalja<n>)
// PORTS
//   Clock        in   1       single clock; all state on rising edge
//   Reset        in   1       synchronous, active-high
//   Hyrja        in   WIDTH   input word
//   HyrjaValid   in   1       Hyrja is written this cycle
//   Sel          in   3       target lane, manual mode only
//   AutoMode     in   1       1 = lane from internal Ptr; 0 = lane from Sel
//   Clear        in   1       sync clear of Ptr, LaneMask, frame state (lane data kept)
//   Dalja0..7    out  WIDTH   registered lane outputs, hold until overwritten
//   LaneMask     out  8       bit n set = lane n written since last frame/Clear
//   Ptr          out  3       current auto-mode write pointer
//   DaljaValid   out  1       1-cycle pulse: auto-mode frame complete
// BEHAVIOUR
//   Reset: Dalja0..7=0, LaneMask=0, Ptr=0, DaljaValid=0, state=IDLE.
//   Latency: written word appears on Dalja<lane> the cycle after the HyrjaValid edge.
//   Write = HyrjaValid & ~Clear. Only lane <lane> updates; other lanes hold.
//   Lane = AutoMode ? Ptr : Sel.
//   FSM states:
//     IDLE: no frame in progress.
//       Write in auto mode -> FILL.
//       Write in manual mode -> stays IDLE.
//     FILL: auto frame partly collected.
//       Auto write with Ptr=7 -> DONE.
//     DONE: DaljaValid=1 this cycle only, then:
//       auto write this cycle -> FILL, lane 0 written, new frame starts.
//       otherwise -> IDLE.
//   Auto write: Ptr <= Ptr+1 mod 8 (7 wraps to 0); LaneMask[Ptr] <= 1.
//   Frame completion (write at Ptr=7):
//     next cycle DaljaValid=1; Dalja7 already valid the same cycle.
//     LaneMask reads 8'hFF during the DONE cycle, then clears to 0.
//     A write in the DONE cycle sets LaneMask=8'h01.
//   Manual write:
//     LaneMask[Sel] <= 1.
//     Ptr unchanged, no FSM transition, never generates DaljaValid.
//   Mode switch mid-frame: Ptr and LaneMask hold; auto writes resume at the held Ptr.
//   Clear:
//     Ptr=0, LaneMask=0, state=IDLE, DaljaValid=0 next cycle; Dalja lanes keep their values.
//     Clear together with HyrjaValid: Clear wins, word dropped.
//   Reset has priority over Clear and writes. Reset mid-frame aborts the frame; no DaljaValid.
//   HyrjaValid=0: all state holds. Sel is ignored while AutoMode=1.
// TESTING
//   1 Reset, WIDTH=8:
//     AutoMode=1, 8 back-to-back writes A0..A7 ->
//     Dalja0..7=A0..A7, DaljaValid pulses exactly once, the cycle after A7.
//     Ptr=0 and LaneMask=8'h00 after the DONE cycle.
//   2 Manual mode: Sel=5, Hyrja=8'h3C, one valid ->
//     Dalja5=8'h3C next cycle, other lanes 0, LaneMask=8'h20, Ptr=0, no DaljaValid.
//   3 Auto mode: write 3 words, then assert Clear together with a 4th word ->
//     4th word dropped, Ptr=0, LaneMask=0, Dalja0..2 retained.
//   4 Auto frame of 8, then a 9th write in the DONE cycle ->
//     DaljaValid=1 once, Dalja0 holds the 9th word, LaneMask=8'h01, Ptr=1.
//   5 Auto: write 5 words, assert Reset for one cycle ->
//     all outputs 0, no DaljaValid; then 8 new writes produce one clean frame.
//   6 Auto: write 4 words, switch to manual and write Sel=6, back to auto and write 4 more ->
//     DaljaValid after 8th auto write; the last auto write overwrites Dalja7; Dalja6 = 3rd post-switch word.

Source files
------------

// File: rtl/demux1ne8_seq.sv
// Registered 1-to-8 demultiplexer / deserializer: routes each valid input word into one of
// eight held output lanes, chosen by Sel (manual) or an internal write pointer (auto frames).
module demux1ne8_seq #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] hyrja_i,
    input  logic             hyrja_valid_i,
    input  logic [2:0]       sel_i,
    input  logic             auto_mode_i,
    input  logic             clear_i,
    output logic [WIDTH-1:0] dalja0_o,
    output logic [WIDTH-1:0] dalja1_o,
    output logic [WIDTH-1:0] dalja2_o,
    output logic [WIDTH-1:0] dalja3_o,
    output logic [WIDTH-1:0] dalja4_o,
    output logic [WIDTH-1:0] dalja5_o,
    output logic [WIDTH-1:0] dalja6_o,
    output logic [WIDTH-1:0] dalja7_o,
    output logic [7:0]       lane_mask_o,
    output logic [2:0]       ptr_o,
    output logic             dalja_valid_o
);

    localparam int unsigned NLANES = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [7:0]       mask_q, mask_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] lane_q [NLANES];
    logic [WIDTH-1:0] lane_d [NLANES];

    logic       write_c;
    logic [2:0] lane_sel_c;

    assign write_c    = hyrja_valid_i & ~clear_i;
    assign lane_sel_c = auto_mode_i ? ptr_q : sel_i;

    // State register
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            ptr_q   <= 3'd0;
            mask_q  <= 8'd0;
            valid_q <= 1'b0;
            for (int i = 0; i < NLANES; i++) begin
                lane_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            mask_q  <= mask_d;
            valid_q <= valid_d;
            lane_q  <= lane_d;
        end
    end

    // Next-state: the DONE cycle drops the completed frame's mask before any new write lands
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        mask_d  = (state_q == DONE) ? 8'd0 : mask_q;
        lane_d  = lane_q;

        if (clear_i) begin
            state_d = IDLE;
            ptr_d   = 3'd0;
            mask_d  = 8'd0;
        end else begin
            if (state_q == DONE) begin
                state_d = IDLE;
            end
            if (write_c) begin
                lane_d[lane_sel_c] = hyrja_i;
                mask_d[lane_sel_c] = 1'b1;
                if (auto_mode_i) begin
                    ptr_d   = ptr_q + 3'd1;
                    state_d = (ptr_q == 3'd7) ? DONE : FILL;
                end
            end
        end

        valid_d = (state_d == DONE);
    end

    assign dalja0_o      = lane_q[0];
    assign dalja1_o      = lane_q[1];
    assign dalja2_o      = lane_q[2];
    assign dalja3_o      = lane_q[3];
    assign dalja4_o      = lane_q[4];
    assign dalja5_o      = lane_q[5];
    assign dalja6_o      = lane_q[6];
    assign dalja7_o      = lane_q[7];
    assign lane_mask_o   = mask_q;
    assign ptr_o         = ptr_q;
    assign dalja_valid_o = valid_q;

endmodule

// File: tb/tb_demux1ne8_seq.sv
// Directed self-checking bench for demux1ne8_seq with WIDTH=8.
module tb_demux1ne8_seq;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] hyrja;
    logic         hyrja_valid;
    logic [2:0]   sel;
    logic         auto_mode;
    logic         clear;
    logic [W-1:0] d0, d1, d2, d3, d4, d5, d6, d7;
    logic [7:0]   lane_mask;
    logic [2:0]   ptr;
    logic         dalja_valid;
    logic [W-1:0] lane [8];

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    demux1ne8_seq #(.WIDTH(W)) dut (
        .clock_i      (clk),
        .reset_i      (reset),
        .hyrja_i      (hyrja),
        .hyrja_valid_i(hyrja_valid),
        .sel_i        (sel),
        .auto_mode_i  (auto_mode),
        .clear_i      (clear),
        .dalja0_o     (d0),
        .dalja1_o     (d1),
        .dalja2_o     (d2),
        .dalja3_o     (d3),
        .dalja4_o     (d4),
        .dalja5_o     (d5),
        .dalja6_o     (d6),
        .dalja7_o     (d7),
        .lane_mask_o  (lane_mask),
        .ptr_o        (ptr),
        .dalja_valid_o(dalja_valid)
    );

    assign lane[0] = d0;
    assign lane[1] = d1;
    assign lane[2] = d2;
    assign lane[3] = d3;
    assign lane[4] = d4;
    assign lane[5] = d5;
    assign lane[6] = d6;
    assign lane[7] = d7;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        hyrja_valid = 1'b0;
        clear = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic wr(input logic [W-1:0] d, input logic am, input logic [2:0] s, input logic clr);
        hyrja = d;
        auto_mode = am;
        sel = s;
        clear = clr;
        hyrja_valid = 1'b1;
        @(posedge clk);
        #1;
        hyrja_valid = 1'b0;
        clear = 1'b0;
    endtask

    task automatic idle();
        hyrja_valid = 1'b0;
        clear = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        hyrja = '0;
        hyrja_valid = 1'b0;
        sel = 3'd0;
        auto_mode = 1'b1;
        clear = 1'b0;
        reset = 1'b0;

        // 1: reset state, then a full auto frame A0..A7
        do_reset();
        for (int i = 0; i < 8; i++) check($sformatf("rst_lane%0d", i), 32'(lane[i]), 32'h0);
        check("rst_mask", 32'(lane_mask), 32'h0);
        check("rst_ptr", 32'(ptr), 32'h0);
        check("rst_valid", 32'(dalja_valid), 32'h0);
        for (int i = 0; i < 8; i++) begin
            wr(8'hA0 + 8'(i), 1'b1, 3'd0, 1'b0);
            if (i < 7) check($sformatf("t1_novalid%0d", i), 32'(dalja_valid), 32'h0);
        end
        check("t1_valid", 32'(dalja_valid), 32'h1);
        check("t1_mask_done", 32'(lane_mask), 32'hFF);
        check("t1_d7", 32'(d7), 32'hA7);
        idle();
        check("t1_valid_once", 32'(dalja_valid), 32'h0);
        check("t1_ptr", 32'(ptr), 32'h0);
        check("t1_mask_after", 32'(lane_mask), 32'h0);
        for (int i = 0; i < 8; i++) check($sformatf("t1_lane%0d", i), 32'(lane[i]), 32'hA0 + 32'(i));

        // 2: manual write to lane 5
        do_reset();
        wr(8'h3C, 1'b0, 3'd5, 1'b0);
        for (int i = 0; i < 8; i++) check($sformatf("t2_lane%0d", i), 32'(lane[i]), (i == 5) ? 32'h3C : 32'h0);
        check("t2_mask", 32'(lane_mask), 32'h20);
        check("t2_ptr", 32'(ptr), 32'h0);
        check("t2_valid", 32'(dalja_valid), 32'h0);
        idle();
        check("t2_valid_later", 32'(dalja_valid), 32'h0);

        // 3: Clear together with a 4th write drops the word
        do_reset();
        for (int i = 0; i < 3; i++) wr(8'hB0 + 8'(i), 1'b1, 3'd7, 1'b0);
        check("t3_ptr_pre", 32'(ptr), 32'h3);
        check("t3_mask_pre", 32'(lane_mask), 32'h07);
        wr(8'hB3, 1'b1, 3'd7, 1'b1);
        check("t3_ptr", 32'(ptr), 32'h0);
        check("t3_mask", 32'(lane_mask), 32'h0);
        check("t3_d0", 32'(d0), 32'hB0);
        check("t3_d1", 32'(d1), 32'hB1);
        check("t3_d2", 32'(d2), 32'hB2);
        check("t3_d3_dropped", 32'(d3), 32'h0);
        check("t3_valid", 32'(dalja_valid), 32'h0);

        // 4: 9th write lands in the DONE cycle
        do_reset();
        for (int i = 0; i < 8; i++) wr(8'hC0 + 8'(i), 1'b1, 3'd0, 1'b0);
        check("t4_valid", 32'(dalja_valid), 32'h1);
        wr(8'hC8, 1'b1, 3'd0, 1'b0);
        check("t4_valid_drop", 32'(dalja_valid), 32'h0);
        check("t4_d0", 32'(d0), 32'hC8);
        check("t4_d1", 32'(d1), 32'hC1);
        check("t4_mask", 32'(lane_mask), 32'h01);
        check("t4_ptr", 32'(ptr), 32'h1);
        idle();
        check("t4_valid_idle", 32'(dalja_valid), 32'h0);

        // 5: Reset mid-frame aborts it, then a clean frame
        do_reset();
        for (int i = 0; i < 5; i++) wr(8'h50 + 8'(i), 1'b1, 3'd0, 1'b0);
        check("t5_ptr_pre", 32'(ptr), 32'h5);
        do_reset();
        for (int i = 0; i < 8; i++) check($sformatf("t5_rst_lane%0d", i), 32'(lane[i]), 32'h0);
        check("t5_rst_mask", 32'(lane_mask), 32'h0);
        check("t5_rst_ptr", 32'(ptr), 32'h0);
        check("t5_rst_valid", 32'(dalja_valid), 32'h0);
        for (int i = 0; i < 8; i++) begin
            wr(8'h60 + 8'(i), 1'b1, 3'd0, 1'b0);
            if (i < 7) check($sformatf("t5_novalid%0d", i), 32'(dalja_valid), 32'h0);
        end
        check("t5_valid", 32'(dalja_valid), 32'h1);
        for (int i = 0; i < 8; i++) check($sformatf("t5_lane%0d", i), 32'(lane[i]), 32'h60 + 32'(i));

        // 6: manual write mid-frame; auto resumes at the held pointer
        do_reset();
        for (int i = 0; i < 4; i++) wr(8'hD0 + 8'(i), 1'b1, 3'd0, 1'b0);
        wr(8'hD4, 1'b0, 3'd6, 1'b0);
        check("t6_ptr_hold", 32'(ptr), 32'h4);
        check("t6_mask_mix", 32'(lane_mask), 32'h4F);
        check("t6_d6_manual", 32'(d6), 32'hD4);
        check("t6_novalid", 32'(dalja_valid), 32'h0);
        for (int i = 0; i < 4; i++) wr(8'hD5 + 8'(i), 1'b1, 3'd1, 1'b0);
        check("t6_valid", 32'(dalja_valid), 32'h1);
        check("t6_d4", 32'(d4), 32'hD5);
        check("t6_d5", 32'(d5), 32'hD6);
        check("t6_d6", 32'(d6), 32'hD7);
        check("t6_d7", 32'(d7), 32'hD8);
        check("t6_d1", 32'(d1), 32'hD1);
        idle();
        check("t6_valid_once", 32'(dalja_valid), 32'h0);
        check("t6_ptr_end", 32'(ptr), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
